// File: rtl/metro_turnstile_gen2.sv
// Turnstile lane controller: card-code check, bounded door-open window, fail-count lockout.
// Optional tailgate detection is enabled by defining METRO_TURNSTILE_TAILGATE_EN.
module metro_turnstile_gen2 #(
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned VALID_CODE  = 9,
    parameter int unsigned OPEN_CYCLES = 8,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           validate_code,
    input  logic [CODE_W-1:0]              access_code,
    input  logic                           pass_sensor,
    output logic                           open_access_door,
    output logic                           deny_pulse,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
    output logic                           tailgate_alarm,
    output logic [1:0]                     state_out
);

    localparam int unsigned TMAX  = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TW    = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
    localparam int unsigned FW    = $clog2(MAX_FAILS + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OPEN    = 2'd1;
    localparam logic [1:0] DENIED  = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] fail_q,  fail_d;
    logic          code_ok;

    assign code_ok = (access_code == CODE_W'(VALID_CODE));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (validate_code) begin
                    if (code_ok) begin
                        state_d = OPEN;
                        timer_d = TW'(OPEN_CYCLES - 1);
                        fail_d  = '0;
                    end else if (fail_q == FW'(MAX_FAILS - 1)) begin
                        state_d = LOCKOUT;
                        timer_d = TW'(LOCK_CYCLES - 1);
                        fail_d  = FW'(MAX_FAILS);
                    end else begin
                        state_d = DENIED;
                        fail_d  = fail_q + FW'(1);
                    end
                end
            end
            OPEN: begin
                // Passage closes the door ahead of timer expiry.
                if (pass_sensor || (timer_q == '0)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DENIED: begin
                state_d = IDLE;
            end
            default: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
`ifdef METRO_TURNSTILE_TAILGATE_EN
                if (pass_sensor) begin
                    state_d = LOCKOUT;
                    timer_d = TW'(LOCK_CYCLES - 1);
                    fail_d  = FW'(MAX_FAILS);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
        end
    end

`ifdef METRO_TURNSTILE_TAILGATE_EN
    logic alarm_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= pass_sensor && (state_q != OPEN);
        end
    end

    assign tailgate_alarm = alarm_q;
`else
    assign tailgate_alarm = 1'b0;
`endif

    assign open_access_door = (state_q == OPEN);
    assign deny_pulse       = (state_q == DENIED);
    assign locked_out       = (state_q == LOCKOUT);
    assign fail_count       = fail_q;
    assign state_out        = state_q;

endmodule

// File: doc/metro_turnstile_gen2.md
Name: metro_turnstile_gen2

Overview:
Parametrised access-gate controller for one turnstile lane. It checks a CODE_W-bit card code against a configured valid code and opens the door for a bounded time. The door closes early on a passage-sensor event. After MAX_FAILS consecutive bad codes it enters a timed lockout. It sits between the card reader front end (validate_code/access_code) and the door actuator and sensor.

Parameters:
CODE_W, 4, access code width in bits
VALID_CODE, 9, code that grants access (CODE_W bits)
OPEN_CYCLES, 8, maximum door-open duration in clk cycles (>=1)
MAX_FAILS, 3, consecutive invalid codes that trigger lockout (>=1)
LOCK_CYCLES, 16, lockout duration in clk cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
validate_code  input  1  access_code is valid this cycle
access_code  input  CODE_W  card code presented
pass_sensor  input  1  person has passed through the gate
open_access_door  output  1  door actuator enable
deny_pulse  output  1  one-cycle pulse on each rejected code
locked_out  output  1  high for the whole lockout period
fail_count  output  $clog2(MAX_FAILS+1)  current consecutive-fail count
tailgate_alarm  output  1  tailgate detect (see Optional Feature)
state_out  output  2  FSM state, for debug

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, timer=0, fail_count=0.
  - open_access_door, deny_pulse, locked_out and tailgate_alarm are all 0.
- State encodings: IDLE=2'd0, OPEN=2'd1, DENIED=2'd2, LOCKOUT=2'd3.
- All outputs are registered. Door, deny and lock outputs are pure decodes of the state register: door=(state==OPEN), deny_pulse=(state==DENIED), locked_out=(state==LOCKOUT).
- IDLE, validate_code=0: stay in IDLE.
- IDLE, validate_code=1, access_code==VALID_CODE:
  - Go to OPEN, load timer=OPEN_CYCLES-1, clear fail_count.
  - Latency: the door is high starting at the first edge after the sampling edge.
- IDLE, validate_code=1, access_code!=VALID_CODE:
  - If fail_count+1==MAX_FAILS: go to LOCKOUT, load timer=LOCK_CYCLES-1, set fail_count=MAX_FAILS.
  - Otherwise: fail_count+=1 and go to DENIED.
- DENIED: lasts exactly 1 cycle, then returns to IDLE. validate_code is ignored (the code is dropped, not queued).
- OPEN:
  - pass_sensor=1 -> IDLE at the next edge. This takes priority over timer expiry.
  - timer==0 -> IDLE.
  - Otherwise timer-=1.
  - The door is therefore high for at most OPEN_CYCLES cycles.
  - validate_code is ignored in OPEN.
- LOCKOUT:
  - timer==0 -> IDLE and clear fail_count. Otherwise timer-=1.
  - Lockout lasts exactly LOCK_CYCLES cycles.
  - validate_code is ignored; fail_count holds at MAX_FAILS.
- pass_sensor outside OPEN has no FSM effect.
- Timer width is $clog2(max(OPEN_CYCLES,LOCK_CYCLES)), minimum 1. The timer never underflows.
- Simultaneous validate_code and pass_sensor in IDLE: validate_code is processed normally.
- Reset asserted mid-operation: all outputs drop immediately, asynchronously. Operation resumes in IDLE on the first edge after reset deasserts.
- MAX_FAILS=1: the first bad code goes straight to LOCKOUT. DENIED is never entered.

Optional Feature:
Macro: METRO_TURNSTILE_TAILGATE_EN
- Defined:
  - pass_sensor=1 sampled while state is IDLE, DENIED or LOCKOUT sets tailgate_alarm=1 for exactly one cycle (registered).
  - A passage while LOCKOUT is active also restarts the lockout timer at LOCK_CYCLES-1.
- Not defined:
  - tailgate_alarm is tied to 0.
  - pass_sensor is ignored outside OPEN.
  - The lockout timer is never restarted.

Test Plan:
All scenarios use default parameters.
- Hold reset=0 for 4 cycles, then release -> state_out=0, all outputs 0, fail_count=0. Assert reset again mid-OPEN -> door drops to 0 without waiting for a clk edge.
- One-cycle validate_code=1, access_code=9, pass_sensor=0 -> open_access_door high for exactly 8 cycles, then state_out=0.
- Code 9 accepted, pass_sensor=1 on the 3rd OPEN cycle -> door falls at the next edge (3 high cycles), state_out=0.
- Codes 1, then 2, each followed by one idle cycle -> two 1-cycle deny_pulse, fail_count=2. Then code 9 -> OPEN, fail_count=0.
- Codes 1, 2, 3 -> third code enters LOCKOUT, locked_out high for exactly 16 cycles. Code 9 presented mid-lockout is ignored (door stays 0). Afterwards state_out=0, fail_count=0.
- Sweep access_code 0..15, one per cycle with validate_code=1 -> codes 0 and 2 deny (code 1 falls in DENIED and is ignored), code 4 locks out, and codes 5..15, including 9, are ignored in LOCKOUT. With METRO_TURNSTILE_TAILGATE_EN, pass_sensor=1 in LOCKOUT -> 1-cycle tailgate_alarm and lockout restarted at 16 cycles.
